// File: rtl/uart_cmd_parser.sv
// Command frame assembler: SYNC, opcode, operand A, operand B, XOR checksum -> ALU command.
// Optional error counter output enabled by defining UART_CMD_ERRCNT_EN.
module uart_cmd_parser #(
    parameter int          DATA_W       = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CLKS = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [3:0]        alu_sel,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              err_chksum,
    output logic              err_frame,
    output logic              err_timeout,
    output logic              err_overrun
`ifdef UART_CMD_ERRCNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam int NB = DATA_W / 8;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        OPA,
        OPB,
        CHECK,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [7:0]        chk_q, chk_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [3:0]        sel_stg_q, sel_stg_d;
    logic [DATA_W-1:0] a_stg_q, a_stg_d;
    logic [DATA_W-1:0] b_stg_q, b_stg_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [3:0]        alu_sel_q, alu_sel_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              err_chksum_q, err_chksum_d;
    logic              err_frame_q, err_frame_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_overrun_q, err_overrun_d;
    logic              in_frame;
    logic              is_sync;
    logic [DATA_W-1:0] rx_shift_in;

    assign in_frame    = (state_q == OPCODE) || (state_q == OPA) ||
                         (state_q == OPB)    || (state_q == CHECK);
    assign is_sync     = rx_valid && (rx_data == SYNC_BYTE);
    // New byte enters at the top so that after NB bytes the first one sits in the LSB.
    assign rx_shift_in = DATA_W'(rx_data) << (DATA_W - 8);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d       = state_q;
        cnt_d         = cnt_q;
        chk_d         = chk_q;
        tmo_d         = '0;
        sel_stg_d     = sel_stg_q;
        a_stg_d       = a_stg_q;
        b_stg_d       = b_stg_q;
        cmd_valid_d   = cmd_valid_q;
        alu_sel_d     = alu_sel_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        err_chksum_d  = 1'b0;
        err_frame_d   = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;

        // A byte on the terminal cycle wins over the timeout.
        if (in_frame && !rx_valid) begin
            if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
                err_timeout_d = 1'b1;
                state_d       = IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (is_sync) begin
                    state_d = OPCODE;
                    chk_d   = '0;
                end
            end
            OPCODE: begin
                if (rx_valid) begin
                    if (rx_data[7:4] != 4'h0) begin
                        err_frame_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        sel_stg_d = rx_data[3:0];
                        chk_d     = chk_q ^ rx_data;
                        cnt_d     = '0;
                        state_d   = OPA;
                    end
                end
            end
            OPA: begin
                if (rx_valid) begin
                    a_stg_d = (a_stg_q >> 8) | rx_shift_in;
                    chk_d   = chk_q ^ rx_data;
                    if (cnt_q == 2'(NB - 1)) begin
                        cnt_d   = '0;
                        state_d = OPB;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OPB: begin
                if (rx_valid) begin
                    b_stg_d = (b_stg_q >> 8) | rx_shift_in;
                    chk_d   = chk_q ^ rx_data;
                    if (cnt_q == 2'(NB - 1)) begin
                        cnt_d   = '0;
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        op_a_d      = a_stg_q;
                        op_b_d      = b_stg_q;
                        alu_sel_d   = sel_stg_q;
                        cmd_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        err_chksum_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            HOLD: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    if (is_sync) begin
                        state_d = OPCODE;
                        chk_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (rx_valid) begin
                    err_overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: staging registers are reset along with the outputs; they are few flops, not a memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            chk_q         <= '0;
            tmo_q         <= '0;
            sel_stg_q     <= '0;
            a_stg_q       <= '0;
            b_stg_q       <= '0;
            cmd_valid_q   <= 1'b0;
            alu_sel_q     <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            err_chksum_q  <= 1'b0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            chk_q         <= chk_d;
            tmo_q         <= tmo_d;
            sel_stg_q     <= sel_stg_d;
            a_stg_q       <= a_stg_d;
            b_stg_q       <= b_stg_d;
            cmd_valid_q   <= cmd_valid_d;
            alu_sel_q     <= alu_sel_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            err_chksum_q  <= err_chksum_d;
            err_frame_q   <= err_frame_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign alu_sel     = alu_sel_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign err_chksum  = err_chksum_q;
    assign err_frame   = err_frame_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;

`ifdef UART_CMD_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;
    logic       err_any;

    assign err_any = err_chksum_d | err_frame_d | err_timeout_d | err_overrun_d;

    always_comb begin
        err_count_d = err_count_q;
        if (err_any && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: an 8-bit instance driven from a vector table,
// plus hand sequences for timeout, 16-bit operands and reset behaviour.
module tb_uart_cmd_parser;

    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        cmd_ready = 1'b0;

    logic        cv8, chk8, frm8, tmo8, ovr8;
    logic [3:0]  sel8;
    logic [7:0]  a8, b8;
    logic        cv16, chk16, frm16, tmo16, ovr16;
    logic [3:0]  sel16;
    logic [15:0] a16, b16;
`ifdef UART_CMD_ERRCNT_EN
    logic [7:0]  ecnt8, ecnt16;
`endif

    int vec_cnt = 0;
    int miss_cnt = 0;

    uart_cmd_parser #(.DATA_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(T)) dut8 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_ready(cmd_ready), .cmd_valid(cv8), .alu_sel(sel8), .op_a(a8), .op_b(b8),
        .err_chksum(chk8), .err_frame(frm8), .err_timeout(tmo8), .err_overrun(ovr8)
`ifdef UART_CMD_ERRCNT_EN
        , .err_count(ecnt8)
`endif
    );

    uart_cmd_parser #(.DATA_W(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(T)) dut16 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_ready(cmd_ready), .cmd_valid(cv16), .alu_sel(sel16), .op_a(a16), .op_b(b16),
        .err_chksum(chk16), .err_frame(frm16), .err_timeout(tmo16), .err_overrun(ovr16)
`ifdef UART_CMD_ERRCNT_EN
        , .err_count(ecnt16)
`endif
    );

    always #10 clk = ~clk;

    // Expected-value layout: {cmd_valid, alu_sel, op_a, op_b, {chksum, frame, timeout, overrun}}
    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic [24:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rdy,
                                input logic cv, input logic [3:0] sel,
                                input logic [7:0] a, input logic [7:0] b, input logic [3:0] err);
        vec_t r;
        r.v   = v;
        r.d   = d;
        r.rdy = rdy;
        r.exp = {cv, sel, a, b, err};
        return r;
    endfunction

    function automatic logic [24:0] pack8();
        return {cv8, sel8, a8, b8, chk8, frm8, tmo8, ovr8};
    endfunction

    function automatic logic [40:0] pack16();
        return {cv16, sel16, a16, b16, chk16, frm16, tmo16, ovr16};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; the byte is sampled at the next rising edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #2;
        check("reset_dut8", 64'(pack8()), 64'd0);
        check("reset_dut16", 64'(pack16()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic command, hold, handshake
        tbl.push_back(mk(1, 8'hA5, 0, 0, 4'h0, 8'h00, 8'h00, 4'h0));
        tbl.push_back(mk(1, 8'h01, 0, 0, 4'h0, 8'h00, 8'h00, 4'h0));
        tbl.push_back(mk(1, 8'h12, 0, 0, 4'h0, 8'h00, 8'h00, 4'h0));
        tbl.push_back(mk(1, 8'h34, 0, 0, 4'h0, 8'h00, 8'h00, 4'h0));
        tbl.push_back(mk(1, 8'h27, 0, 1, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(0, 8'h00, 0, 1, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        // Bad checksum: one-cycle strobe, outputs unchanged
        tbl.push_back(mk(1, 8'hA5, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'h01, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'h12, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'h34, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'h28, 0, 0, 4'h1, 8'h12, 8'h34, 4'h8));
        tbl.push_back(mk(0, 8'h00, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        // Noise in IDLE, then 02 05 03 with checksum 04
        tbl.push_back(mk(1, 8'h00, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'hFF, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'h3C, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'hA5, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'h02, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'h05, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'h03, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'h04, 0, 1, 4'h2, 8'h05, 8'h03, 4'h0));
        // Overrun while holding, then SYNC coinciding with the handshake
        tbl.push_back(mk(1, 8'h55, 0, 1, 4'h2, 8'h05, 8'h03, 4'h1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 4'h2, 8'h05, 8'h03, 4'h0));
        tbl.push_back(mk(1, 8'hA5, 1, 0, 4'h2, 8'h05, 8'h03, 4'h0));
        tbl.push_back(mk(1, 8'h01, 0, 0, 4'h2, 8'h05, 8'h03, 4'h0));
        tbl.push_back(mk(1, 8'h12, 0, 0, 4'h2, 8'h05, 8'h03, 4'h0));
        tbl.push_back(mk(1, 8'h34, 0, 0, 4'h2, 8'h05, 8'h03, 4'h0));
        tbl.push_back(mk(1, 8'h27, 0, 1, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        // Illegal opcode, following byte ignored in IDLE
        tbl.push_back(mk(1, 8'hA5, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'h31, 0, 0, 4'h1, 8'h12, 8'h34, 4'h4));
        tbl.push_back(mk(1, 8'h01, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        // SYNC value inside a frame is data: 00 ^ A5 ^ A5 = 00
        tbl.push_back(mk(1, 8'hA5, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'hA5, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'hA5, 0, 0, 4'h1, 8'h12, 8'h34, 4'h0));
        tbl.push_back(mk(1, 8'h00, 0, 1, 4'h0, 8'hA5, 8'hA5, 4'h0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 4'h0, 8'hA5, 8'hA5, 4'h0));

        foreach (tbl[i]) begin
            rx_valid  = tbl[i].v;
            rx_data   = tbl[i].d;
            cmd_ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'(pack8()), 64'(tbl[i].exp));
        end
        rx_valid  = 1'b0;
        cmd_ready = 1'b0;

        // Timeout: byte on the terminal cycle is accepted, full silence times out once
        send(8'hA5);
        send(8'h01);
        for (int i = 0; i < T - 1; i++) begin
            check("gap_no_timeout", 64'(tmo8), 64'd0);
            @(negedge clk);
        end
        send(8'h12);
        for (int i = 0; i < T; i++) begin
            check("wait_no_timeout", 64'(pack8()), 64'(pack8() & ~25'h2));
            check("timeout_not_early", 64'(tmo8), 64'd0);
            @(negedge clk);
        end
        check("timeout_strobe", 64'(tmo8), 64'd1);
        check("timeout_exclusive", 64'({chk8, frm8, ovr8, cv8}), 64'd0);
        @(negedge clk);
        check("timeout_one_cycle", 64'(tmo8), 64'd0);
        send(8'h02);
        send(8'h05);
        send(8'h03);
        send(8'h04);
        check("after_timeout_idle", 64'({cv8, chk8, frm8, tmo8, ovr8}), 64'd0);

        // 16-bit operands: checksum is 03^34^12^78^56 = 0B, so 0F is a mismatch
        pulse_reset();
        send(8'hA5); send(8'h03); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
        send(8'h0F);
        check("w16_bad_chksum", 64'(pack16()), 64'({1'b0, 4'h0, 16'h0, 16'h0, 4'h8}));
        send(8'hA5); send(8'h03); send(8'h34); send(8'h12); send(8'h78); send(8'h56);
        send(8'h0B);
        check("w16_cmd", 64'(pack16()), 64'({1'b1, 4'h3, 16'h1234, 16'h5678, 4'h0}));

        // Reset while holding a command clears everything immediately
        rst_n = 1'b0;
        #1;
        check("rst_hold_dut16", 64'(pack16()), 64'd0);
        check("rst_hold_dut8", 64'(pack8()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_release_quiet", 64'(pack16()), 64'd0);
        end

        // Reset mid-frame: the tail of the frame is then ignored
        send(8'hA5); send(8'h03); send(8'h34);
        rst_n = 1'b0;
        #1;
        check("rst_midframe", 64'(pack16()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h12); send(8'h78); send(8'h56); send(8'h0B);
        check("midframe_dropped_dut16", 64'(pack16()), 64'd0);
        check("midframe_dropped_dut8", 64'(pack8()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
